// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_ctrl_pkg;

    localparam int DefRegAddrWidth = 5;

    typedef enum logic [1:0] {
        DBG_RUN    = 2'd0,
        DBG_DRAIN  = 2'd1,
        DBG_HALTED = 2'd2,
        DBG_STEP   = 2'd3
    } dbg_state_e;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_me;
        logic flush_id;
        logic flush_ex;
        logic flush_me;
    } hz_ctrl_t;

    localparam hz_ctrl_t HzNone = '0;
    localparam hz_ctrl_t HzStallAll = '{stall_if: 1'b1, stall_id: 1'b1, stall_ex: 1'b1,
                                        stall_me: 1'b1, default: 1'b0};
    localparam hz_ctrl_t HzDataHazard = '{stall_if: 1'b1, stall_id: 1'b1, stall_ex: 1'b1,
                                          flush_me: 1'b1, default: 1'b0};
    localparam hz_ctrl_t HzBranch = '{flush_id: 1'b1, default: 1'b0};
    localparam hz_ctrl_t HzFetchBubble = '{stall_if: 1'b1, flush_id: 1'b1, default: 1'b0};
    localparam hz_ctrl_t HzReset = '{flush_id: 1'b1, flush_ex: 1'b1, flush_me: 1'b1,
                                     default: 1'b0};

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side bundle of operand, stage-status and control lines
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int RegAddrWidth = DefRegAddrWidth,
    parameter int NumSrc       = 2,
    parameter int NumFwd       = 2,
    parameter int CntWidth     = 16
);
    localparam int SelW = $clog2(NumFwd + 1);

    logic [NumSrc*RegAddrWidth-1:0] iSrcAddr;
    logic [NumSrc-1:0]              iSrcUsed;
    logic [NumFwd*RegAddrWidth-1:0] iFwdAddr;
    logic [NumFwd-1:0]              iFwdWrEn;
    logic [NumFwd-1:0]              iFwdRdy;
    logic                           iBrTrue;
    logic                           iStall_IF;
    logic                           iStall_ME;
    logic                           iDbgHalt;
    logic                           iDbgStep;
    logic                           iDbgResume;
    logic [NumSrc*SelW-1:0]         oFwdSel;
    logic                           oStall_IF;
    logic                           oStall_ID;
    logic                           oStall_EX;
    logic                           oStall_ME;
    logic                           oFlush_ID;
    logic                           oFlush_EX;
    logic                           oFlush_ME;
    logic                           oDbgHalted;
    logic [CntWidth-1:0]            oStallCnt;

    modport master (
        output iSrcAddr, iSrcUsed, iFwdAddr, iFwdWrEn, iFwdRdy, iBrTrue,
               iStall_IF, iStall_ME, iDbgHalt, iDbgStep, iDbgResume,
        input  oFwdSel, oStall_IF, oStall_ID, oStall_EX, oStall_ME,
               oFlush_ID, oFlush_EX, oFlush_ME, oDbgHalted, oStallCnt
    );

    modport slave (
        input  iSrcAddr, iSrcUsed, iFwdAddr, iFwdWrEn, iFwdRdy, iBrTrue,
               iStall_IF, iStall_ME, iDbgHalt, iDbgStep, iDbgResume,
        output oFwdSel, oStall_IF, oStall_ID, oStall_EX, oStall_ME,
               oFlush_ID, oFlush_EX, oFlush_ME, oDbgHalted, oStallCnt
    );

endinterface

// File: rtl/hazard_ctrl_fwd_match.sv
// rtl/hazard_ctrl_fwd_match.sv - per-operand priority match against the forwarding stages
module fwd_match #(
    parameter int RegAddrWidth = 5,
    parameter int NumFwd       = 2,
    parameter int SelW         = 2
) (
    input  logic [RegAddrWidth-1:0]        src_addr_i,
    input  logic                           src_used_i,
    input  logic [NumFwd*RegAddrWidth-1:0] fwd_addr_i,
    input  logic [NumFwd-1:0]              fwd_wr_en_i,
    input  logic [NumFwd-1:0]              fwd_rdy_i,
    output logic [SelW-1:0]                sel_o,
    output logic                           not_rdy_o
);

    // Scan oldest to youngest so the youngest matching stage is the last assignment.
    always_comb begin
        sel_o     = '0;
        not_rdy_o = 1'b0;
        if (src_used_i && (src_addr_i != '0)) begin
            for (int k = NumFwd - 1; k >= 0; k--) begin
                if (fwd_wr_en_i[k] &&
                    (fwd_addr_i[k*RegAddrWidth +: RegAddrWidth] == src_addr_i)) begin
                    sel_o     = SelW'(k + 1);
                    not_rdy_o = !fwd_rdy_i[k];
                end
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding selects, stall/flush arbitration and debug run-control
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int RegAddrWidth = DefRegAddrWidth,
    parameter int NumSrc       = 2,
    parameter int NumFwd       = 2,
    parameter int DrainDepth   = 3,
    parameter int CntWidth     = 16,
    localparam int SelW        = $clog2(NumFwd + 1)
) (
    input logic          iClk,
    input logic          iRst,
    hazard_ctrl_if.slave hz_if
);

    localparam int DcW = (DrainDepth > 1) ? $clog2(DrainDepth) : 1;
    localparam logic [DcW-1:0] DcLast = DcW'(DrainDepth - 1);

    logic [NumSrc-1:0]      src_nrdy;
    logic [NumSrc*SelW-1:0] fwd_sel;
    logic                   hz;

    dbg_state_e          state_q, state_d;
    logic [DcW-1:0]      dc_q, dc_d;
    logic                halted_q;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    hz_ctrl_t            ctrl;

    generate
        for (genvar s = 0; s < NumSrc; s++) begin : g_match
            fwd_match #(
                .RegAddrWidth (RegAddrWidth),
                .NumFwd       (NumFwd),
                .SelW         (SelW)
            ) u_match (
                .src_addr_i  (hz_if.iSrcAddr[s*RegAddrWidth +: RegAddrWidth]),
                .src_used_i  (hz_if.iSrcUsed[s]),
                .fwd_addr_i  (hz_if.iFwdAddr),
                .fwd_wr_en_i (hz_if.iFwdWrEn),
                .fwd_rdy_i   (hz_if.iFwdRdy),
                .sel_o       (fwd_sel[s*SelW +: SelW]),
                .not_rdy_o   (src_nrdy[s])
            );
        end
    endgenerate

    assign hz = |src_nrdy;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q  <= DBG_RUN;
            dc_q     <= '0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            dc_q     <= dc_d;
            halted_q <= (state_d == DBG_HALTED);
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dc_d    = dc_q;
        case (state_q)
            DBG_RUN: begin
                if (hz_if.iDbgHalt) begin
                    state_d = DBG_DRAIN;
                    dc_d    = '0;
                end
            end
            DBG_DRAIN: begin
                // A memory stall freezes ID..ME, so it does not advance the drain.
                if (!hz_if.iStall_ME) begin
                    if (dc_q == DcLast) begin
                        state_d = DBG_HALTED;
                    end else begin
                        dc_d = dc_q + 1'b1;
                    end
                end
            end
            DBG_HALTED: begin
                if (hz_if.iDbgResume) begin
                    state_d = DBG_RUN;
                end else if (hz_if.iDbgStep) begin
                    state_d = DBG_STEP;
                end
            end
            DBG_STEP: begin
                if (!hz_if.iStall_IF && !hz_if.iStall_ME) begin
                    state_d = DBG_DRAIN;
                    dc_d    = '0;
                end
            end
            default: state_d = DBG_RUN;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (hz && !hz_if.iStall_ME && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        ctrl = HzNone;
        if (hz_if.iStall_ME) begin
            ctrl = HzStallAll;
        end else if (hz) begin
            ctrl = HzDataHazard;
        end else if (hz_if.iBrTrue) begin
            ctrl = HzBranch;
        end else if (hz_if.iStall_IF) begin
            ctrl = HzFetchBubble;
        end
        // Draining gates fetch, but only where IF/ID is free to take the bubble.
        if ((state_q == DBG_DRAIN) && !hz_if.iStall_ME && !hz) begin
            ctrl = HzFetchBubble;
        end
        if (state_q == DBG_HALTED) begin
            ctrl = HzStallAll;
        end
        if (iRst) begin
            ctrl = HzReset;
        end
    end

    assign hz_if.oFwdSel    = iRst ? '0 : fwd_sel;
    assign hz_if.oStall_IF  = ctrl.stall_if;
    assign hz_if.oStall_ID  = ctrl.stall_id;
    assign hz_if.oStall_EX  = ctrl.stall_ex;
    assign hz_if.oStall_ME  = ctrl.stall_me;
    assign hz_if.oFlush_ID  = ctrl.flush_id;
    assign hz_if.oFlush_EX  = ctrl.flush_ex;
    assign hz_if.oFlush_ME  = ctrl.flush_me;
    assign hz_if.oDbgHalted = halted_q;
    assign hz_if.oStallCnt  = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int RAW = 5;
    localparam int NS  = 2;
    localparam int NF  = 2;
    localparam int DD  = 3;
    localparam int CW  = 4;
    localparam int SW  = $clog2(NF + 1);

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_HALT  = 2;
    localparam int M_STEP  = 3;

    typedef struct {
        logic [NS*RAW-1:0] src_addr;
        logic [NS-1:0]     used;
        logic [NF*RAW-1:0] fwd_addr;
        logic [NF-1:0]     wr_en;
        logic [NF-1:0]     rdy;
        logic              br;
        logic              sif;
        logic              sme;
        logic [NS*SW-1:0]  exp_sel;
        logic [6:0]        exp_ctrl;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   m_mode   = M_RUN;
    int   m_left   = 0;
    int   m_cnt    = 0;
    vec_t vecs [14];

    always #5 clk = ~clk;

    hazard_ctrl_if #(.RegAddrWidth(RAW), .NumSrc(NS), .NumFwd(NF), .CntWidth(CW)) bus ();

    hazard_ctrl #(
        .RegAddrWidth (RAW),
        .NumSrc       (NS),
        .NumFwd       (NF),
        .DrainDepth   (DD),
        .CntWidth     (CW)
    ) dut (
        .iClk  (clk),
        .iRst  (rst),
        .hz_if (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic int m_src_sel(input int s);
        int sel = 0;
        if (bus.iSrcUsed[s] && (bus.iSrcAddr[s*RAW +: RAW] != '0)) begin
            for (int k = 0; k < NF; k++) begin
                if (sel == 0 && bus.iFwdWrEn[k] &&
                    (bus.iFwdAddr[k*RAW +: RAW] == bus.iSrcAddr[s*RAW +: RAW])) begin
                    sel = k + 1;
                end
            end
        end
        return sel;
    endfunction

    function automatic logic m_hz();
        logic h = 1'b0;
        for (int s = 0; s < NS; s++) begin
            int sel = m_src_sel(s);
            if (sel != 0 && !bus.iFwdRdy[sel-1]) h = 1'b1;
        end
        return h;
    endfunction

    function automatic logic [NS*SW-1:0] m_fsel();
        logic [NS*SW-1:0] v = '0;
        if (!rst) begin
            for (int s = 0; s < NS; s++) v[s*SW +: SW] = SW'(m_src_sel(s));
        end
        return v;
    endfunction

    function automatic logic [6:0] m_ctrl();
        if (rst) return 7'b0000_111;
        if (m_mode == M_HALT) return 7'b1111_000;
        if (bus.iStall_ME) return 7'b1111_000;
        if (m_hz()) return 7'b1110_001;
        if (m_mode == M_DRAIN) return 7'b1000_100;
        if (bus.iBrTrue) return 7'b0000_100;
        if (bus.iStall_IF) return 7'b1000_100;
        return 7'b0000_000;
    endfunction

    function automatic logic [6:0] dut_ctrl();
        return {bus.oStall_IF, bus.oStall_ID, bus.oStall_EX, bus.oStall_ME,
                bus.oFlush_ID, bus.oFlush_EX, bus.oFlush_ME};
    endfunction

    task automatic m_step();
        if (rst) begin
            m_mode = M_RUN;
            m_left = 0;
            m_cnt  = 0;
        end else begin
            if (m_hz() && !bus.iStall_ME && m_cnt < (1 << CW) - 1) m_cnt++;
            case (m_mode)
                M_RUN:   if (bus.iDbgHalt) begin m_mode = M_DRAIN; m_left = DD; end
                M_DRAIN: if (!bus.iStall_ME) begin
                             m_left--;
                             if (m_left == 0) m_mode = M_HALT;
                         end
                M_HALT:  if (bus.iDbgResume) m_mode = M_RUN;
                         else if (bus.iDbgStep) m_mode = M_STEP;
                M_STEP:  if (!bus.iStall_IF && !bus.iStall_ME) begin m_mode = M_DRAIN; m_left = DD; end
                default: m_mode = M_RUN;
            endcase
        end
    endtask

    // Called one time unit after a rising edge with inputs already driven.
    task automatic apply(input string name, input bit tab = 1'b0,
                         input logic [NS*SW-1:0] tsel = '0, input logic [6:0] tctrl = '0);
        #2;
        chk({name, ":fwd_sel"}, 32'(bus.oFwdSel), 32'(m_fsel()));
        chk({name, ":ctrl"}, 32'(dut_ctrl()), 32'(m_ctrl()));
        chk({name, ":halted"}, 32'(bus.oDbgHalted), 32'(m_mode == M_HALT));
        chk({name, ":cnt"}, 32'(bus.oStallCnt), 32'(m_cnt));
        if (tab) begin
            chk({name, ":tab_sel"}, 32'(bus.oFwdSel), 32'(tsel));
            chk({name, ":tab_ctrl"}, 32'(dut_ctrl()), 32'(tctrl));
        end
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic set_idle();
        bus.iSrcAddr   = '0;
        bus.iSrcUsed   = '0;
        bus.iFwdAddr   = '0;
        bus.iFwdWrEn   = '0;
        bus.iFwdRdy    = '1;
        bus.iBrTrue    = 1'b0;
        bus.iStall_IF  = 1'b0;
        bus.iStall_ME  = 1'b0;
        bus.iDbgHalt   = 1'b0;
        bus.iDbgStep   = 1'b0;
        bus.iDbgResume = 1'b0;
    endtask

    task automatic set_load_use();
        set_idle();
        bus.iSrcAddr = {5'd7, 5'd0};
        bus.iSrcUsed = 2'b10;
        bus.iFwdAddr = {5'd0, 5'd7};
        bus.iFwdWrEn = 2'b01;
        bus.iFwdRdy  = 2'b10;
    endtask

    initial begin
        vecs[0]  = '{{5'd0, 5'd5}, 2'b01, {5'd5, 5'd5}, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0001, 7'b0000_000};
        vecs[1]  = '{{5'd0, 5'd0}, 2'b11, {5'd0, 5'd0}, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000, 7'b0000_000};
        vecs[2]  = '{{5'd7, 5'd3}, 2'b11, {5'd3, 5'd7}, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0110, 7'b0000_000};
        vecs[3]  = '{{5'd7, 5'd0}, 2'b10, {5'd0, 5'd7}, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 4'b0100, 7'b1110_001};
        vecs[4]  = '{{5'd7, 5'd0}, 2'b10, {5'd0, 5'd7}, 2'b01, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0100, 7'b0000_000};
        vecs[5]  = '{{5'd0, 5'd9}, 2'b01, {5'd9, 5'd9}, 2'b10, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0010, 7'b0000_000};
        vecs[6]  = '{{5'd0, 5'd9}, 2'b00, {5'd9, 5'd9}, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000, 7'b0000_000};
        vecs[7]  = '{{5'd0, 5'd0}, 2'b00, {5'd0, 5'd0}, 2'b00, 2'b11, 1'b1, 1'b0, 1'b1, 4'b0000, 7'b1111_000};
        vecs[8]  = '{{5'd0, 5'd0}, 2'b00, {5'd0, 5'd0}, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 4'b0000, 7'b0000_100};
        vecs[9]  = '{{5'd0, 5'd0}, 2'b00, {5'd0, 5'd0}, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 4'b0000, 7'b1000_100};
        vecs[10] = '{{5'd7, 5'd0}, 2'b10, {5'd0, 5'd7}, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 4'b0100, 7'b1110_001};
        vecs[11] = '{{5'd0, 5'd0}, 2'b00, {5'd0, 5'd0}, 2'b00, 2'b11, 1'b1, 1'b1, 1'b0, 4'b0000, 7'b0000_100};
        vecs[12] = '{{5'd7, 5'd0}, 2'b10, {5'd0, 5'd7}, 2'b01, 2'b10, 1'b0, 1'b0, 1'b1, 4'b0100, 7'b1111_000};
        vecs[13] = '{{5'd0, 5'd4}, 2'b01, {5'd4, 5'd4}, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 4'b0001, 7'b0000_000};

        rst = 1'b1;
        set_idle();
        @(posedge clk);
        m_step();
        #1;
        apply("reset");
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            set_idle();
            bus.iSrcAddr  = vecs[i].src_addr;
            bus.iSrcUsed  = vecs[i].used;
            bus.iFwdAddr  = vecs[i].fwd_addr;
            bus.iFwdWrEn  = vecs[i].wr_en;
            bus.iFwdRdy   = vecs[i].rdy;
            bus.iBrTrue   = vecs[i].br;
            bus.iStall_IF = vecs[i].sif;
            bus.iStall_ME = vecs[i].sme;
            apply($sformatf("vec%0d", i), 1'b1, vecs[i].exp_sel, vecs[i].exp_ctrl);
        end

        set_idle();
        bus.iDbgHalt = 1'b1;
        apply("halt_req");
        set_idle();
        apply("drain0");
        apply("drain1");
        chk("halt_edge3", 32'(bus.oDbgHalted), 32'd0);
        apply("drain2");
        chk("halt_edge4", 32'(bus.oDbgHalted), 32'd1);
        bus.iDbgHalt = 1'b1;
        apply("halt_ignored");
        set_idle();
        chk("halt_ignored_still", 32'(bus.oDbgHalted), 32'd1);
        bus.iDbgStep = 1'b1;
        apply("step_req");
        set_idle();
        #1;
        chk("step_if_released", 32'(bus.oStall_IF), 32'd0);
        apply("step_cycle");
        chk("step_if_gated", 32'(bus.oStall_IF), 32'd1);
        apply("step_drain0");
        apply("step_drain1");
        apply("step_drain2");
        chk("step_rehalt", 32'(bus.oDbgHalted), 32'd1);
        bus.iDbgResume = 1'b1;
        bus.iDbgStep   = 1'b1;
        apply("resume_step");
        set_idle();
        chk("resume_wins", 32'(bus.oDbgHalted), 32'd0);
        apply("resume_run0");
        chk("resume_stays_run", 32'(bus.oStall_IF), 32'd0);

        rst = 1'b1;
        apply("sat_rst");
        rst = 1'b0;
        set_load_use();
        for (int i = 0; i < 20; i++) apply($sformatf("sat%0d", i));
        chk("sat_cnt", 32'(bus.oStallCnt), 32'd15);
        apply("sat_extra");
        chk("sat_no_wrap", 32'(bus.oStallCnt), 32'd15);

        set_idle();
        bus.iDbgHalt = 1'b1;
        apply("rh_halt");
        set_idle();
        for (int i = 0; i < DD; i++) apply($sformatf("rh_drain%0d", i));
        chk("rh_halted", 32'(bus.oDbgHalted), 32'd1);
        rst = 1'b1;
        bus.iSrcAddr = {5'd0, 5'd5};
        bus.iSrcUsed = 2'b01;
        bus.iFwdAddr = {5'd5, 5'd5};
        bus.iFwdWrEn = 2'b11;
        #1;
        chk("rst_forced_ctrl", 32'(dut_ctrl()), 32'b0000_111);
        chk("rst_forced_sel", 32'(bus.oFwdSel), 32'd0);
        apply("rh_reset");
        rst = 1'b0;
        set_idle();
        chk("rh_halted_clr", 32'(bus.oDbgHalted), 32'd0);
        chk("rh_cnt_clr", 32'(bus.oStallCnt), 32'd0);
        apply("rh_run");

        for (int i = 0; i < 1500; i++) begin
            for (int s = 0; s < NS; s++) bus.iSrcAddr[s*RAW +: RAW] = 5'($urandom_range(0, 3));
            for (int k = 0; k < NF; k++) begin
                bus.iFwdAddr[k*RAW +: RAW] = 5'($urandom_range(0, 3));
                bus.iFwdRdy[k] = ($urandom_range(0, 3) != 0);
            end
            bus.iSrcUsed   = 2'($urandom_range(0, 3));
            bus.iFwdWrEn   = 2'($urandom_range(0, 3));
            bus.iBrTrue    = ($urandom_range(0, 3) == 0);
            bus.iStall_IF  = ($urandom_range(0, 4) == 0);
            bus.iStall_ME  = ($urandom_range(0, 5) == 0);
            bus.iDbgHalt   = ($urandom_range(0, 9) == 0);
            bus.iDbgStep   = ($urandom_range(0, 5) == 0);
            bus.iDbgResume = ($urandom_range(0, 7) == 0);
            rst            = ($urandom_range(0, 149) == 0);
            apply($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised successor to the fixed 2-operand, 2-source hazard unit.
- Decides operand forwarding, load-use/data-hazard stalls, structural stall propagation and branch flushes for the in-order IF/ID/EX/ME/WB pipeline.
- Adds a debug run-control FSM (halt/drain/step/resume) and a saturating stall-cycle counter.
- Sits beside the pipeline stages in the processor top. Drives per-stage stall and flush lines, and per-operand forward selects to EX.

Parameters:
- RegAddrWidth, 5, register address width; address 0 is hard-wired zero.
- NumSrc, 2, source operands per instruction in EX (3 for fused ops).
- NumFwd, 2, forwarding sources; index 0 is youngest (EX/ME), NumFwd-1 is oldest.
- DrainDepth, 3, non-stalled cycles needed to empty ID..ME after fetch is gated.
- CntWidth, 16, stall counter width.
- SelW, $clog2(NumFwd+1), derived width of one forward select.

Ports:
- iClk, in, 1: clock.
- iRst, in, 1: synchronous reset, active-high.
- iSrcAddr, in, NumSrc*RegAddrWidth: source register addresses of the instruction in ID/EX.
- iSrcUsed, in, NumSrc: operand actually read.
- iFwdAddr, in, NumFwd*RegAddrWidth: destination register of each later stage.
- iFwdWrEn, in, NumFwd: stage writes its rd.
- iFwdRdy, in, NumFwd: rd value is available now (0 for a load not yet returned).
- iBrTrue, in, 1: ID resolved a taken branch/jump.
- iStall_IF, in, 1: instruction fetch not complete.
- iStall_ME, in, 1: data memory busy.
- iDbgHalt, in, 1: debug halt request (pulse).
- iDbgStep, in, 1: debug single-step request (pulse).
- iDbgResume, in, 1: debug resume request (pulse).
- oFwdSel, out, NumSrc*SelW: 0 selects the register file; k selects forwarding source k-1.
- oStall_IF, out, 1: hold the IF stage.
- oStall_ID, out, 1: hold the ID stage.
- oStall_EX, out, 1: hold the EX stage.
- oStall_ME, out, 1: hold the ME stage.
- oFlush_ID, out, 1: load a bubble into IF/ID.
- oFlush_EX, out, 1: load a bubble into ID/EX.
- oFlush_ME, out, 1: load a bubble into EX/ME.
- oDbgHalted, out, 1: core is halted.
- oStallCnt, out, CntWidth: count of data-hazard stall cycles.

Behaviour:
- Forwarding (combinational):
  - For each operand s with iSrcUsed[s]=1 and iSrcAddr[s]!=0, select the lowest k with iFwdWrEn[k]=1 and iFwdAddr[k]==iSrcAddr[s]; oFwdSel[s]=k+1.
  - If no source matches, oFwdSel[s]=0.
- Data hazard: hz=1 when any operand's selected source has iFwdRdy[k]=0.
  - Action: stall IF/ID/EX, set oFlush_ME (bubble into ME).
- Priority, one cycle, highest first:
  1. iStall_ME: all four stalls=1, no flushes.
  2. Data hazard (hz).
  3. Branch: iBrTrue sets oFlush_ID.
  4. iStall_IF: oStall_IF=1, oFlush_ID=1.
  - A branch during hz or iStall_ME is suppressed. ID is held, so the branch re-asserts next cycle.
- Debug FSM, states RUN, DRAIN, HALTED, STEP:
  - RUN: iDbgHalt goes to DRAIN and clears drain counter dc.
  - DRAIN: oStall_IF=1, oFlush_ID=1. dc increments on each cycle without iStall_ME. At dc==DrainDepth-1 with no iStall_ME, go to HALTED.
  - HALTED: all stalls=1, oDbgHalted=1 (registered, asserted the cycle the state enters HALTED).
    - iDbgResume goes to RUN.
    - Otherwise iDbgStep goes to STEP.
    - iDbgHalt is ignored.
    - Resume and step together: resume wins.
  - STEP: stalls follow normal rules for one cycle, releasing IF. If iStall_IF or iStall_ME holds the fetch, remain in STEP. Otherwise go to DRAIN with dc=0.
  - iDbgHalt in DRAIN or STEP is ignored.
  - Data-hazard and ME stalls are still honoured inside DRAIN/STEP.
- Stall counter: increments on each cycle with hz=1 and not iStall_ME. Saturates at all-ones and does not wrap.
- Reset (iRst=1 at a clock edge):
  - Registered state returns to RUN; dc=0; oStallCnt=0; oDbgHalted=0.
  - While iRst is high, combinational outputs are forced: stalls=0, all flushes=1, oFwdSel=0.
  - Reset mid-DRAIN or mid-HALTED returns to RUN the next cycle.

Decomposition:
- Shared pipeline package holds:
  - the dbg_state_e enum (RUN, DRAIN, HALTED, STEP);
  - a packed hz_ctrl_t struct bundling the stall and flush outputs for the top;
  - the RegAddrWidth default.
- One sub-module, fwd_match: per-operand priority matcher. Inputs are one address and the iFwd* vectors; outputs are the select and a not-ready flag. It is instantiated NumSrc times via generate.

Test Plan:
- Forwarding: src0=x5 used, iFwdAddr={x5,x5}, WrEn=11, Rdy=11 -> oFwdSel[0]=1 (youngest wins), no stall; src=x0 -> oFwdSel=0.
- Load-use: src1=x7, stage0 rd=x7, Rdy[0]=0 for 1 cycle -> oStall_IF/ID/EX=1, oFlush_ME=1, oStallCnt 0->1. Next cycle Rdy=1 -> stalls drop, oFwdSel[1]=1.
- ME stall vs branch: iStall_ME=1 and iBrTrue=1 together -> all stalls=1, oFlush_ID=0. After iStall_ME drops, oFlush_ID=1.
- Halt/step/resume with DrainDepth=3 and no mem stall:
  - Halt pulse -> oDbgHalted=1 at the 4th edge after the request.
  - Step -> IF released exactly 1 cycle, halted again 3 cycles later.
  - Resume+step same cycle -> RUN.
- Counter saturation (CntWidth=4): hz held 20 cycles -> oStallCnt=15.
- Reset while HALTED: iRst 1 cycle -> oDbgHalted=0, oStallCnt=0, all flushes=1 during reset, RUN after.
